// File: rtl/ltc2308_responder_if.sv
// Pin and host-port bundle between an LTC2308 master (or bench) and the responder.
// The master modport drives the serial pins and the channel write port.
interface ltc2308_responder_if;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;
  logic        wr_en;
  logic [2:0]  wr_chan;
  logic [11:0] wr_data;
  logic [5:0]  cfg_word;
  logic        frame_done;
  logic        frame_err;

  modport master (
    output adc_convst, adc_sck, adc_sdi, wr_en, wr_chan, wr_data,
    input  adc_sdo, cfg_word, frame_done, frame_err
  );

  modport slave (
    input  adc_convst, adc_sck, adc_sdi, wr_en, wr_chan, wr_data,
    output adc_sdo, cfg_word, frame_done, frame_err
  );
endinterface

// File: rtl/ltc2308_responder.sv
// LTC2308 converter stand-in: oversamples CONVST/SCK/SDI in the clk domain and
// returns a transformed channel register value on SDO, MSB first.
module ltc2308_responder #(
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  ltc2308_responder_if.slave bus
);

  localparam int               CNT_W     = $clog2(CONV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CONV_CYCLES - 1);
  localparam logic [5:0]       CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_READY,
    S_SHIFT
  } state_t;

  // cfg bit layout: [5]=S/D [4]=O/S [3]=S1 [2]=S0 [1]=UNI [0]=SLP
  function automatic logic [11:0] f_transform(input logic [11:0] value,
                                              input logic        single_ended,
                                              input logic        unipolar);
    if (!single_ended) return 12'h000;
    if (unipolar)      return value;
    return value ^ 12'h800;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync_convst;
  logic [SYNC_STAGES-1:0] r_sync_sck;
  logic [SYNC_STAGES-1:0] r_sync_sdi;
  logic                   r_convst_d;
  logic                   r_sck_d;

  logic w_convst;
  logic w_sck;
  logic w_sdi;
  logic w_convst_rise;
  logic w_sck_rise;
  logic w_sck_fall;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_idx;
  logic [2:0]       r_cfg_cnt;
  logic [5:0]       r_cfg_word;
  logic [5:0]       r_next_cfg;
  logic             r_sdo_bit;
  logic             r_sdo;
  logic             r_frame_done;
  logic             r_frame_err;
  logic [11:0]      r_data;
  logic [11:0]      r_chan [8];

  logic        w_start;
  logic        w_abort;
  logic        w_snap;
  logic [2:0]  w_ch;
  logic [11:0] w_snap_val;
  logic [3:0]  w_idx_dn;

  // Stage: pin synchronizers and edge-detect register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_convst <= '0;
      r_sync_sck    <= '0;
      r_sync_sdi    <= '0;
      r_convst_d    <= 1'b0;
      r_sck_d       <= 1'b0;
    end else begin
      r_sync_convst <= {r_sync_convst[SYNC_STAGES-2:0], bus.adc_convst};
      r_sync_sck    <= {r_sync_sck[SYNC_STAGES-2:0],    bus.adc_sck};
      r_sync_sdi    <= {r_sync_sdi[SYNC_STAGES-2:0],    bus.adc_sdi};
      r_convst_d    <= w_convst;
      r_sck_d       <= w_sck;
    end
  end

  assign w_convst      = r_sync_convst[SYNC_STAGES-1];
  assign w_sck         = r_sync_sck[SYNC_STAGES-1];
  assign w_sdi         = r_sync_sdi[SYNC_STAGES-1];
  assign w_convst_rise = w_convst & ~r_convst_d;
  assign w_sck_rise    = w_sck & ~r_sck_d;
  assign w_sck_fall    = ~w_sck & r_sck_d;

  // A CONVST rise restarts from any state except CONV, where it is ignored.
  assign w_start    = w_convst_rise && (r_state != S_CONV);
  assign w_abort    = w_start && ((r_state == S_READY) || (r_state == S_SHIFT));
  assign w_snap     = (r_state == S_CONV) && (r_cnt == '0);
  assign w_ch       = {r_cfg_word[3], r_cfg_word[2], r_cfg_word[4]};
  assign w_snap_val = f_transform(r_chan[w_ch], r_cfg_word[5], r_cfg_word[1]);
  assign w_idx_dn   = r_idx - 4'd1;

  // Stage: host channel register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_chan[i] <= 12'h000;
    end else if (bus.wr_en) begin
      r_chan[bus.wr_chan] <= bus.wr_data;
    end
  end

  // Stage: conversion snapshot; reads the register file before a same-cycle write lands
  always_ff @(posedge clk) begin
    if (w_snap) r_data <= w_snap_val;
  end

  // Stage: frame state machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= 4'd0;
      r_cfg_cnt    <= 3'd0;
      r_cfg_word   <= CFG_RESET;
      r_next_cfg   <= CFG_RESET;
      r_sdo_bit    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_start) begin
        if (r_cfg_cnt == 3'd6) r_cfg_word <= r_next_cfg;
        r_frame_err <= w_abort;
        r_cfg_cnt   <= 3'd0;
        r_cnt       <= CNT_LOAD;
        r_sdo_bit   <= 1'b0;
        r_state     <= S_CONV;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sdo_bit <= 1'b0;
          end
          S_CONV: begin
            if (w_sck_rise || w_sck_fall) r_frame_err <= 1'b1;
            if (w_snap) r_state <= S_READY;
            else        r_cnt   <= r_cnt - 1'b1;
          end
          S_READY: begin
            if (!w_convst) begin
              r_sdo_bit <= r_data[11];
              r_idx     <= 4'd11;
              r_state   <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (w_sck_rise && (r_cfg_cnt < 3'd6)) begin
              r_next_cfg <= {r_next_cfg[4:0], w_sdi};
              r_cfg_cnt  <= r_cfg_cnt + 3'd1;
            end
            if (w_sck_fall) begin
              if (r_idx == 4'd0) begin
                r_sdo_bit    <= 1'b0;
                r_frame_done <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_idx     <= w_idx_dn;
                r_sdo_bit <= r_data[w_idx_dn];
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Stage: SDO output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sdo <= 1'b0;
    else          r_sdo <= r_sdo_bit;
  end

  assign bus.adc_sdo    = r_sdo;
  assign bus.cfg_word   = r_cfg_word;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Directed bench for the LTC2308 responder: drives frames as an ADC master would
// and compares received SDO words and status against hand-computed values.
module tb_ltc2308_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic [11:0] rx;

  ltc2308_responder_if bus ();

  ltc2308_responder #(.CONV_CYCLES(80), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_chan(input logic [2:0] ch, input logic [11:0] val);
    bus.wr_en = 1'b1; bus.wr_chan = ch; bus.wr_data = val;
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic start_conv();
    bus.adc_convst = 1'b1;
    tick(4);
    bus.adc_convst = 1'b0;
    tick(100);
  endtask

  task automatic shift_bits(input logic [5:0] cfg, input int n, output logic [11:0] word);
    logic [5:0] c;
    c = cfg;
    word = 12'h000;
    for (int i = 0; i < n; i++) begin
      bus.adc_sdi = c[5];
      c = {c[4:0], 1'b0};
      tick(8);
      word = {word[10:0], bus.adc_sdo};
      bus.adc_sck = 1'b1;
      tick(8);
      bus.adc_sck = 1'b0;
    end
    bus.adc_sdi = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    bus.adc_convst = 1'b0; bus.adc_sck = 1'b0; bus.adc_sdi = 1'b0;
    bus.wr_en = 1'b0; bus.wr_chan = 3'd0; bus.wr_data = 12'h000;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    total++; if (bus.adc_sdo !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b want=0", bus.adc_sdo); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.frame_done); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.frame_err); end
    total++; if (bus.cfg_word !== 6'b100010) begin bad++; $display("FAIL reset_cfg got=%b want=100010", bus.cfg_word); end
  endtask

  task automatic test_ch0();
    int d0;
    write_chan(3'd0, 12'hABC);
    d0 = done_cnt;
    start_conv();
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'hABC) begin bad++; $display("FAIL ch0_first got=%h want=abc", rx); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ch0_done got=%0d want=1", done_cnt - d0); end
    total++; if (bus.adc_sdo !== 1'b0) begin bad++; $display("FAIL ch0_sdo_after got=%b want=0", bus.adc_sdo); end
    start_conv();
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'hABC) begin bad++; $display("FAIL ch0_second got=%h want=abc", rx); end
    total++; if (bus.cfg_word !== 6'b100010) begin bad++; $display("FAIL ch0_cfg got=%b want=100010", bus.cfg_word); end
    d0 = done_cnt;
    bus.adc_sck = 1'b1; tick(8); bus.adc_sck = 1'b0; tick(8);
    bus.adc_sck = 1'b1; tick(8); bus.adc_sck = 1'b0; tick(8);
    total++; if (bus.adc_sdo !== 1'b0) begin bad++; $display("FAIL overshift_sdo got=%b want=0", bus.adc_sdo); end
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL overshift_done got=%0d want=0", done_cnt - d0); end
  endtask

  task automatic test_ch5_transforms();
    write_chan(3'd5, 12'h123);
    start_conv();
    shift_bits(6'b111010, 12, rx);
    total++; if (rx !== 12'hABC) begin bad++; $display("FAIL ch5_setup got=%h want=abc", rx); end
    start_conv();
    shift_bits(6'b111000, 12, rx);
    total++; if (rx !== 12'h123) begin bad++; $display("FAIL ch5_uni got=%h want=123", rx); end
    total++; if (bus.cfg_word !== 6'b111010) begin bad++; $display("FAIL ch5_uni_cfg got=%b want=111010", bus.cfg_word); end
    start_conv();
    shift_bits(6'b011010, 12, rx);
    total++; if (rx !== 12'h923) begin bad++; $display("FAIL ch5_bipolar got=%h want=923", rx); end
    total++; if (bus.cfg_word !== 6'b111000) begin bad++; $display("FAIL ch5_bip_cfg got=%b want=111000", bus.cfg_word); end
    start_conv();
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'h000) begin bad++; $display("FAIL ch5_diff got=%h want=000", rx); end
    total++; if (bus.cfg_word !== 6'b011010) begin bad++; $display("FAIL ch5_diff_cfg got=%b want=011010", bus.cfg_word); end
  endtask

  task automatic test_abort();
    int d0, e0;
    start_conv();
    shift_bits(6'b111010, 5, rx);
    e0 = err_cnt; d0 = done_cnt;
    start_conv();
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL abort_err got=%0d want=1", err_cnt - e0); end
    total++; if (bus.cfg_word !== 6'b100010) begin bad++; $display("FAIL abort_cfg got=%b want=100010", bus.cfg_word); end
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'hABC) begin bad++; $display("FAIL abort_next got=%h want=abc", rx); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_sck_during_conv();
    int e0;
    e0 = err_cnt;
    bus.adc_convst = 1'b1;
    tick(4);
    bus.adc_convst = 1'b0;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      bus.adc_sck = 1'b1; tick(4);
      bus.adc_sck = 1'b0; tick(4);
    end
    tick(76);
    total++; if (err_cnt - e0 !== 6) begin bad++; $display("FAIL conv_sck_err got=%0d want=6", err_cnt - e0); end
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'hABC) begin bad++; $display("FAIL conv_sck_data got=%h want=abc", rx); end
  endtask

  task automatic test_convst_high();
    int e0;
    e0 = err_cnt;
    bus.adc_convst = 1'b1;
    tick(95);
    total++; if (bus.adc_sdo !== 1'b0) begin bad++; $display("FAIL hold_sdo got=%b want=0", bus.adc_sdo); end
    bus.adc_convst = 1'b0;
    tick(10);
    total++; if (bus.adc_sdo !== 1'b1) begin bad++; $display("FAIL hold_msb got=%b want=1", bus.adc_sdo); end
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'hABC) begin bad++; $display("FAIL hold_data got=%h want=abc", rx); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL hold_err got=%0d want=0", err_cnt - e0); end
  endtask

  task automatic test_write_race();
    bus.adc_convst = 1'b1;
    tick(4);
    bus.adc_convst = 1'b0;
    tick(78);
    bus.wr_en = 1'b1; bus.wr_chan = 3'd0; bus.wr_data = 12'h5A5;
    tick(1);
    bus.wr_en = 1'b0;
    tick(20);
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'hABC) begin bad++; $display("FAIL race_old got=%h want=abc", rx); end
    start_conv();
    shift_bits(6'b111010, 12, rx);
    total++; if (rx !== 12'h5A5) begin bad++; $display("FAIL race_new got=%h want=5a5", rx); end
  endtask

  task automatic test_reset_mid();
    start_conv();
    total++; if (bus.cfg_word !== 6'b111010) begin bad++; $display("FAIL mid_cfg_pre got=%b want=111010", bus.cfg_word); end
    shift_bits(6'b100010, 6, rx);
    total++; if (bus.adc_sdo !== 1'b1) begin bad++; $display("FAIL mid_bit6 got=%b want=1", bus.adc_sdo); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (bus.adc_sdo !== 1'b0) begin bad++; $display("FAIL mid_sdo_async got=%b want=0", bus.adc_sdo); end
    total++; if (bus.cfg_word !== 6'b100010) begin bad++; $display("FAIL mid_cfg_reset got=%b want=100010", bus.cfg_word); end
    tick(2);
    reset_n = 1'b1;
    tick(2);
    start_conv();
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'h000) begin bad++; $display("FAIL mid_chan_cleared got=%h want=000", rx); end
    write_chan(3'd0, 12'h5A5);
    start_conv();
    shift_bits(6'b100010, 12, rx);
    total++; if (rx !== 12'h5A5) begin bad++; $display("FAIL mid_fresh_ch0 got=%h want=5a5", rx); end
  endtask

  initial begin
    test_reset();
    test_ch0();
    test_ch5_transforms();
    test_abort();
    test_sck_during_conv();
    test_convst_high();
    test_write_race();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ltc2308_responder.md
# ltc2308_responder

Synthesizable responder model of the LTC2308 serial ADC. It receives CONVST/SCK/SDI from an ADC master and returns 12-bit sample data on SDO. Sample values come from an 8-entry channel register file loaded by a host write port. The block sits on the FPGA in place of the physical converter, for loopback bring-up and for bench verification of the ADC master, and oversamples the serial pins in the clk domain.

## Interface
- CONV_CYCLES, 80: clk cycles from CONVST rising edge (after sync) to data ready; 1.6 µs at 50 MHz.
- SYNC_STAGES, 2: synchronizer flops per serial input; legal values are 2 and 3.
- clk  in  1  system clock; must be ≥ 8× SCK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- adc_convst  in  1  conversion start from the master.
- adc_sck  in  1  serial clock from the master.
- adc_sdi  in  1  config bits from the master, MSB first: S/D, O/S, S1, S0, UNI, SLP.
- adc_sdo  out  1  serial result, MSB first.
- wr_en  in  1  host write strobe.
- wr_chan  in  3  channel register index.
- wr_data  in  12  channel value.
- cfg_word  out  6  config in force for the current conversion.
- frame_done  out  1  one-cycle pulse after the 12th SCK falling edge.
- frame_err  out  1  one-cycle pulse on an aborted frame or on SCK activity during CONV.

## Operation
- All three serial inputs pass through SYNC_STAGES flops, followed by one edge-detect register. All state logic is clocked on posedge clk.
- State machine:
  - IDLE: CONVST rise → CONV, counter loaded with CONV_CYCLES-1.
  - CONV: counter decrements. At 0, snapshot data = chan_reg[ch] transformed by cfg_word, then → READY.
  - READY: when CONVST is low, drive data[11] on SDO, bit index = 11, → SHIFT.
  - SHIFT:
    - SCK rise with cfg bit count < 6: shift SDI into next_cfg.
    - SCK fall: index decrements and SDO = data[index].
    - After the 12th fall: SDO=0, frame_done pulses, → IDLE.
- Channel decode: ch = {S1, S0, O/S}.
- Data transform:
  - UNI=1: value unchanged.
  - UNI=0: value ^ 12'h800 (offset binary to two's complement).
  - S/D=0 (differential): data 12'h000.
- next_cfg is copied to cfg_word at the next CONVST rise, and only if all 6 bits were received in the previous frame. Otherwise cfg_word is kept.
- SLP is captured but has no effect.
- Register file: a write with wr_en writes chan_reg[wr_chan] in the same cycle. A write during SHIFT does not alter data already snapshotted.

## Timing
- Reset values:
  - adc_sdo=0, frame_done=0, frame_err=0.
  - cfg_word=6'b100010 (single-ended, ch0, unipolar).
  - next_cfg=6'b100010.
  - All chan_reg=0.
  - State IDLE.
- Reset mid-frame returns to IDLE immediately. SDO drops to 0 asynchronously.
- Pin-to-action latency: SYNC_STAGES+1 clk.
  - SDO changes SYNC_STAGES+2 clk after an SCK falling edge at the pin.
  - Data ready SYNC_STAGES+1+CONV_CYCLES clk after the CONVST rise.
- CONVST rise during READY or SHIFT: frame_err pulses, the current frame is abandoned, and a new CONV starts in the same cycle.
- SCK edge during CONV: frame_err pulses, the edge is ignored, and conversion continues.
- More than 12 SCK falls: SDO stays 0 (block already in IDLE).
- CONVST rise during CONV: ignored, no error.
- CONVST high when CONV ends: READY holds and SDO=0 until CONVST falls.
- Simultaneous wr_en and snapshot on the same channel: the snapshot takes the old value.

## Test plan
- Write ch0=12'hABC. Frame with SDI config 100010. Next frame → SDO bits 1010_1011_1100 MSB-first, frame_done pulses once, cfg_word=100010.
- Write ch5=12'h123. Frame sends config 1_110_1_0 (O/S=1, S1=1, S0=0 → ch5, per ch={S1,S0,O/S}); following frame → SDO=12'h123, cfg_word=6'b111010.
- Same ch5 with UNI=0 config 111000 → next frame SDO=12'h923. With S/D=0 → 12'h000.
- CONVST pulse after only 5 SCK falls → frame_err pulses, cfg_word unchanged, next conversion completes normally.
- SCK toggles 3 times during CONV → frame_err pulses, data still delivered correctly after CONV_CYCLES.
- reset_n asserted at bit 6 of SHIFT → SDO=0 immediately, cfg_word=100010, a fresh frame after release returns ch0 data.
